// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - issue-side operand fetch with write scoreboard, RAW/WAW stalls,
// same-cycle writeback bypass and registered operand bundle.
module operand_fetch #(
  parameter bit BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        iss_valid,
  output logic        iss_ready,
  input  logic [3:0]  iss_src0,
  input  logic [3:0]  iss_src1,
  input  logic [3:0]  iss_dst,
  input  logic        iss_wen,
  output logic [3:0]  rd0_num,
  output logic [3:0]  rd1_num,
  input  logic [31:0] rd0_data,
  input  logic [31:0] rd1_data,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic [3:0]  op_dst,
  output logic        op_wen,
  input  logic        wb_valid,
  input  logic [3:0]  wb_num,
  input  logic [31:0] wb_data,
  output logic        wr_en,
  output logic [3:0]  wr_num,
  output logic [31:0] wr_data,
  output logic        sb_err
);

  // Bit 0 stays zero so r0 never reads as pending and register numbers index directly.
  logic [15:0] pending;
  logic [15:0] pending_nxt;
  logic [15:0] wb_hit;
  logic        src0_haz;
  logic        src1_haz;
  logic        waw_haz;
  logic        out_free;
  logic        accept;
  logic        dst_wen;
  logic        wb_bad;

  assign rd0_num = iss_src0;
  assign rd1_num = iss_src1;
  assign wr_en   = wb_valid && (wb_num != 4'd0);
  assign wr_num  = wb_num;
  assign wr_data = wb_data;

  // One-hot of the register being written back this cycle; r0 writebacks never hit.
  always_comb begin
    wb_hit = '0;
    if (wb_valid && (wb_num != 4'd0)) wb_hit[wb_num] = 1'b1;
  end

  always_comb begin
    if (BYPASS) begin
      src0_haz = pending[iss_src0] && !wb_hit[iss_src0];
      src1_haz = pending[iss_src1] && !wb_hit[iss_src1];
    end else begin
      src0_haz = pending[iss_src0] || wb_hit[iss_src0];
      src1_haz = pending[iss_src1] || wb_hit[iss_src1];
    end
  end

  assign waw_haz   = iss_wen && pending[iss_dst] && !wb_hit[iss_dst];
  assign out_free  = !op_valid || op_ready;
  assign iss_ready = out_free && !src0_haz && !src1_haz && !waw_haz;
  assign accept    = iss_valid && iss_ready;
  assign dst_wen   = iss_wen && (iss_dst != 4'd0);
  assign wb_bad    = wb_valid && !pending[wb_num];

  // Clear from writeback first, then set from accept, so a same-register collision stays pending.
  always_comb begin
    pending_nxt = pending & ~wb_hit;
    if (accept && dst_wen) pending_nxt[iss_dst] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= '0;
      op_valid <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      op_dst   <= '0;
      op_wen   <= 1'b0;
      sb_err   <= 1'b0;
    end else begin
      pending <= pending_nxt;
      if (wb_bad) sb_err <= 1'b1;
      if (accept) begin
        op_valid <= 1'b1;
        op_a     <= wb_hit[iss_src0] ? wb_data : rd0_data;
        op_b     <= wb_hit[iss_src1] ? wb_data : rd1_data;
        op_dst   <= iss_dst;
        op_wen   <= dst_wen;
      end else if (op_ready) begin
        op_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Issue-side operand fetch and writeback controller for the register file. It drives both read ports and the single write port of the 15-entry register file (r1..r15, r0 hard-wired to zero). It accepts instructions over a valid/ready handshake and tracks outstanding writes in a scoreboard, stalling on RAW and WAW hazards. It bypasses same-cycle writeback data and presents registered operands to the execute stage.

## Interface
- BYPASS, 1: 1 = forward same-cycle writeback data to sources; 0 = stall instead.
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- iss_valid  in  1  issue request valid.
- iss_ready  out  1  issue request accepted this cycle when high with iss_valid.
- iss_src0, iss_src1  in  4  source register numbers.
- iss_dst  in  4  destination register number.
- iss_wen  in  1  instruction writes iss_dst.
- rd0_num, rd1_num  out  4  register file read addresses; combinational copies of iss_src0/iss_src1.
- rd0_data, rd1_data  in  32  register file read data; combinational, r0 reads 0.
- op_valid  out  1  operand bundle valid.
- op_ready  in  1  execute stage consumes bundle.
- op_a, op_b  out  32  operands for src0/src1.
- op_dst  out  4  destination register number.
- op_wen  out  1  destination write enable; 0 when iss_dst was 0.
- wb_valid  in  1  execute result returning.
- wb_num  in  4  result register number.
- wb_data  in  32  result data.
- wr_en  out  1  register file write enable = wb_valid && wb_num!=0.
- wr_num  out  4  = wb_num.
- wr_data  out  32  = wb_data.
- sb_err  out  1  sticky: writeback to a register that is not pending, or wb_num==0 with wb_valid.

## Operation
- Scoreboard: pending[15:1] holds one bit per register. r0 is never pending.
- Source hazard for src s (s!=0): pending[s] && !(wb_valid && wb_num==s && BYPASS).
- With BYPASS=0, a source also stalls if wb_valid && wb_num==s.
- WAW hazard: iss_wen && iss_dst!=0 && pending[iss_dst] && !(wb_valid && wb_num==iss_dst).
- Output free: !op_valid || op_ready.
- iss_ready = output free && no source hazard && no WAW hazard. It does not depend on iss_valid.
- Accept = iss_valid && iss_ready. On accept:
  - op_a = (wb_valid && wb_num==src0 && src0!=0) ? wb_data : rd0_data. op_b is formed the same way from src1.
  - op_dst = iss_dst; op_wen = iss_wen && iss_dst!=0; op_valid <= 1.
  - pending[iss_dst] is set if op_wen.
- Output register: if op_valid && op_ready and no accept, then op_valid <= 0. op_* are held stable while op_valid && !op_ready.
- Writeback: wb_valid clears pending[wb_num]. The regfile write is driven combinationally in the same cycle.
- Simultaneous events: a set (accept) and a clear (wb) on the same register in one cycle resolve to set.
- Error: wb_valid with wb_num==0, or with pending[wb_num]==0, sets sb_err. sb_err is cleared only by reset.

## Timing
- Reset (async, rst_n low): pending=0, op_valid=0, op_a=op_b=0, op_dst=0, op_wen=0, sb_err=0.
- Combinational outputs under reset: iss_ready=1 once rst_n deasserts; wr_* follow wb_*.
- Reset mid-operation drops all outstanding scoreboard entries and any held bundle.
- Latency: an accept in cycle N puts the bundle on op_* from cycle N+1 (registered).
- Throughput: 1 instruction/cycle when op_ready stays high and there are no hazards.
- RAW on a result in flight: issue stalls until the wb cycle. With BYPASS=1 it issues in the wb cycle itself; with BYPASS=0 it issues in wb cycle+1.
- sb_err rises the cycle after the offending wb.

## Test plan
- Reset, then issue r1<=r0,r0 (wen) followed by r2<=r1,r1. Required: second stalls (iss_ready=0). wb r1=0xDEADBEEF then issues the same cycle with op_a=op_b=0xDEADBEEF. Repeat with BYPASS=0: issues one cycle later, data read from the regfile.
- Back-to-back 4 independent issues, op_ready=1. Required: 4 consecutive op_valid cycles, pending={r3,r4,r5,r6}, each starting the cycle after its accept.
- op_ready=0 for 3 cycles with a bundle held. Required: op_* are stable, iss_ready=0, and a new accept occurs in the cycle op_ready returns.
- WAW: issue r5 dst twice with no wb. Required: the second waits. A wb to r5 in the same cycle as the second issue accepts it, and pending[5] stays 1.
- wb_valid to r7 while not pending, and to r0. Required: sb_err=1 the next cycle; wr_en=1 for r7 and 0 for r0.
- Assert rst_n=0 mid-stream with pending=0x00F0 and op_valid=1. Required: outputs drop to 0 immediately without a clock edge; pending=0 after release.
